// File: rtl/alu_issue_seq_if.sv
// Command, ALU-drive and result signals of the ALU issue sequencer.
// slave = sequencer side, master = command producer / ALU / result consumer side.
interface alu_issue_seq_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       cmd_op;
    logic             cmd_chain;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [CW-1:0]    fifo_count;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, alu_result, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, fifo_count
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, alu_result, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, fifo_count
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Command FIFO plus IDLE/ISSUE/HOLD sequencer feeding a combinational ALU.
// Define ALU_SEQ_CHAIN_EN to let a command take the previous result as operand A.
module alu_issue_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    alu_issue_seq_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [2:0]       mem_op_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             cmd_ready;
    logic             push, pop, capture, res_take, empty;

`ifdef ALU_SEQ_CHAIN_EN
    logic             mem_chain_q [DEPTH];
`else
    logic             unused_chain;
    assign unused_chain = bus.cmd_chain;
`endif

    // Full blocks the push even when a pop happens in the same cycle.
    assign cmd_ready = rst_n && (count_q != CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = bus.cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]  <= bus.cmd_a;
            mem_b_q[wr_ptr_q]  <= bus.cmd_b;
            mem_op_q[wr_ptr_q] <= bus.cmd_op;
`ifdef ALU_SEQ_CHAIN_EN
            mem_chain_q[wr_ptr_q] <= bus.cmd_chain;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = ISSUE;
            ISSUE:   state_d = HOLD;
            HOLD:    if (bus.res_ready) state_d = empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        capture  = 1'b0;
        res_take = 1'b0;
        case (state_q)
            IDLE:  pop = !empty;
            ISSUE: capture = 1'b1;
            HOLD: begin
                res_take = bus.res_ready;
                pop      = bus.res_ready && !empty;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        if (pop) begin
`ifdef ALU_SEQ_CHAIN_EN
            alu_a_d = mem_chain_q[rd_ptr_q] ? res_data_q : mem_a_q[rd_ptr_q];
`else
            alu_a_d = mem_a_q[rd_ptr_q];
`endif
            alu_b_d  = mem_b_q[rd_ptr_q];
            alu_op_d = mem_op_q[rd_ptr_q];
        end
        res_data_d  = capture ? bus.alu_result : res_data_q;
        res_valid_d = res_valid_q;
        if (capture) begin
            res_valid_d = 1'b1;
        end else if (res_take) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with an adder stub standing in for the ALU.
module tb_alu_issue_seq;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   max_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);

    alu_issue_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

    assign bus.alu_result = bus.alu_a + bus.alu_b + WIDTH'(bus.alu_op);

    alu_issue_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_hs(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic chain);
        bit acc;
        int guard;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        bus.cmd_chain = chain;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 30) begin
            acc = bus.cmd_ready;
            tick;
            guard++;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_chain = 1'b0;
        check_val({"push_", tag}, 32'(acc), 32'd1);
    endtask

    task automatic collect(input int budget, input bit chk_gap, input string tag);
        int  left;
        int  last;
        bit  first;
        left  = budget;
        last  = 0;
        first = 1'b1;
        while (exp_q.size() > 0 && left > 0) begin
            tick;
            left--;
            if (bus.res_valid && bus.res_ready) begin
                check_val({tag, "_data"}, 32'(bus.res_data), 32'(exp_q.pop_front()));
                if (chk_gap && !first) check_val({tag, "_gap"}, 32'(cyc - last), 32'd2);
                first = 1'b0;
                last  = cyc;
            end
        end
        check_val({tag, "_remaining"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.cmd_chain = 1'b0;
        bus.res_ready = 1'b1;
        tick;
        tick;
        check_val("rst_count",     32'(bus.fifo_count), 32'd0);
        check_val("rst_cmd_ready", 32'(bus.cmd_ready),  32'd0);
        check_val("rst_res_valid", 32'(bus.res_valid),  32'd0);
        check_val("rst_res_data",  32'(bus.res_data),   32'd0);
        check_val("rst_alu_a",     32'(bus.alu_a),      32'd0);
        check_val("rst_alu_op",    32'(bus.alu_op),     32'd0);
        rst_n = 1'b1;
        #1;
        check_val("rst_release_ready", 32'(bus.cmd_ready), 32'd1);

        // Single command latency
        push_hs("single", 8'h80, 8'h01, 3'd0, 1'b0);
        check_val("single_count_n",  32'(bus.fifo_count), 32'd1);
        tick;
        check_val("single_alu_a",    32'(bus.alu_a),     32'h80);
        check_val("single_alu_b",    32'(bus.alu_b),     32'h01);
        check_val("single_alu_op",   32'(bus.alu_op),    32'd0);
        check_val("single_valid_n1", 32'(bus.res_valid), 32'd0);
        tick;
        check_val("single_valid_n2", 32'(bus.res_valid), 32'd1);
        check_val("single_data_n2",  32'(bus.res_data),  32'h81);
        tick;
        check_val("single_valid_n3", 32'(bus.res_valid), 32'd0);
        check_val("single_data_kept", 32'(bus.res_data), 32'h81);
        check_val("single_alu_kept", 32'(bus.alu_a),     32'h80);

        // Fill and backpressure
        bus.res_ready = 1'b0;
        push_hs("fill0", 8'h20, 8'h01, 3'd2, 1'b0);
        check_val("fill_cnt0", 32'(bus.fifo_count), 32'd1);
        push_hs("fill1", 8'h21, 8'h01, 3'd2, 1'b0);
        check_val("fill_cnt1", 32'(bus.fifo_count), 32'd1);
        push_hs("fill2", 8'h22, 8'h01, 3'd2, 1'b0);
        check_val("fill_cnt2", 32'(bus.fifo_count), 32'd2);
        push_hs("fill3", 8'h23, 8'h01, 3'd2, 1'b0);
        check_val("fill_cnt3", 32'(bus.fifo_count), 32'd3);
        push_hs("fill4", 8'h24, 8'h01, 3'd2, 1'b0);
        check_val("fill_cnt4", 32'(bus.fifo_count), 32'd4);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'h25;
        bus.cmd_b     = 8'h01;
        bus.cmd_op    = 3'd2;
        for (int i = 0; i < 3; i++) begin
            check_val("stall_ready", 32'(bus.cmd_ready),  32'd0);
            check_val("stall_valid", 32'(bus.res_valid),  32'd1);
            check_val("stall_data",  32'(bus.res_data),   32'h23);
            check_val("stall_count", 32'(bus.fifo_count), 32'd4);
            tick;
        end
        bus.res_ready = 1'b1;
        tick;
        bus.res_ready = 1'b0;
        check_val("full_pop_count", 32'(bus.fifo_count), 32'd3);
        check_val("full_pop_valid", 32'(bus.res_valid),  32'd0);
        check_val("full_pop_ready", 32'(bus.cmd_ready),  32'd1);
        tick;
        bus.cmd_valid = 1'b0;
        check_val("late_push_count", 32'(bus.fifo_count), 32'd4);
        check_val("second_res_data", 32'(bus.res_data),   32'h24);
        bus.res_ready = 1'b1;
        exp_q = '{8'h25, 8'h26, 8'h27, 8'h28};
        collect(40, 1'b0, "fill");
        tick;
        check_val("fill_drained", 32'(bus.fifo_count), 32'd0);

        // Streaming order and throughput
        max_cnt = 0;
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        fork
            begin
                for (int i = 0; i < 8; i++) push_hs("stream", 8'(i), 8'h10, 3'd1, 1'b0);
            end
            collect(80, 1'b1, "stream");
        join
        check_val("stream_max_count", 32'(max_cnt), 32'd4);
        tick;

        // Reset while holding a result with two entries queued
        bus.res_ready = 1'b0;
        push_hs("rst0", 8'h31, 8'h02, 3'd5, 1'b0);
        push_hs("rst1", 8'h32, 8'h02, 3'd5, 1'b0);
        push_hs("rst2", 8'h33, 8'h02, 3'd5, 1'b0);
        check_val("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        check_val("pre_rst_valid", 32'(bus.res_valid),  32'd1);
        check_val("pre_rst_data",  32'(bus.res_data),   32'h38);
        rst_n = 1'b0;
        #1;
        check_val("in_rst_ready", 32'(bus.cmd_ready), 32'd0);
        tick;
        rst_n = 1'b1;
        #1;
        check_val("mid_rst_valid", 32'(bus.res_valid),  32'd0);
        check_val("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        check_val("mid_rst_alu_a", 32'(bus.alu_a),      32'd0);
        check_val("mid_rst_alu_b", 32'(bus.alu_b),      32'd0);
        check_val("mid_rst_alu_op", 32'(bus.alu_op),    32'd0);
        check_val("mid_rst_data",  32'(bus.res_data),   32'd0);
        check_val("mid_rst_ready", 32'(bus.cmd_ready),  32'd1);
        bus.res_ready = 1'b1;
        push_hs("post_rst", 8'h40, 8'h01, 3'd0, 1'b0);
        exp_q = '{8'h41};
        collect(20, 1'b0, "post_rst");
        tick;

        // Result chaining into operand A
        push_hs("chain0", 8'h05, 8'h03, 3'd0, 1'b0);
        push_hs("chain1", 8'hFF, 8'h01, 3'd0, 1'b1);
`ifdef ALU_SEQ_CHAIN_EN
        exp_q = '{8'h08, 8'h09};
`else
        exp_q = '{8'h08, 8'h00};
`endif
        collect(30, 1'b0, "chain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
